// File: rtl/nios_pio_pkg.sv
// Shared constants for the nios_pio_irq parallel I/O port: register map,
// edge-capture selection and IRQ mode selection.
package nios_pio_pkg;

    // Word addresses on slave s1
    localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
    localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd1;
    localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd2;
    localparam logic [2:0] PIO_ADDR_OUTREAD = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR  = 3'd5;

    // Capture edge selection
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Interrupt source selection
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/nios_pio_sync.sv
// Input synchroniser for the whole in_port bus followed by an edge detector
// that compares the synchronised value with the previous sample.
module nios_pio_sync
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;
    logic [WIDTH-1:0]                  prev;

    // Shift chain; prev resets to 0 so a high input through reset reads as a rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            stg  <= '0;
            prev <= '0;
        end else begin
            stg  <= {stg[SYNC_STAGES-2:0], in_port};
            prev <= stg[SYNC_STAGES-1];
        end
    end

    assign sync_in = stg[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_pulse = ~sync_in & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_pulse = sync_in ^ prev;
        end else begin : g_rise
            assign edge_pulse = sync_in & ~prev;
        end
    endgenerate

endmodule

// File: rtl/nios_pio_irq.sv
// Avalon-MM parallel I/O port: output register, synchronised input with edge
// capture, per-bit IRQ mask and registered IRQ.
// Optional feature: define NIOS_PIO_SETCLR_EN to enable the atomic OUTSET (4)
// and OUTCLR (5) write ports; otherwise writes there are ignored.
module nios_pio_irq
    import nios_pio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter int          IRQ_TYPE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] ec_clr;
    logic [31:0]      rd_next;
    logic             unused_wd;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];
    // Upper writedata bits are don't-care when WIDTH < 32
    assign unused_wd = ^writedata;

    nios_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .sync_in    (sync_in),
        .edge_pulse (edge_pulse)
    );

    // Output register: DATA write replaces, optional set/clear ports modify per bit
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else if (wr) begin
            case (address)
                PIO_ADDR_DATA:   out_port <= wd;
`ifdef NIOS_PIO_SETCLR_EN
                PIO_ADDR_OUTSET: out_port <= out_port | wd;
                PIO_ADDR_OUTCLR: out_port <= out_port & ~wd;
`endif
                default:         out_port <= out_port;
            endcase
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset)
            irqmask <= '0;
        else if (wr && address == PIO_ADDR_IRQMASK)
            irqmask <= wd;
    end

    assign ec_clr = (wr && address == PIO_ADDR_EDGECAP) ? wd : '0;

    // Edge capture: write-1-to-clear, a same-cycle edge keeps the bit set
    always_ff @(posedge clk) begin
        if (reset)
            edgecapture <= '0;
        else
            edgecapture <= (edgecapture & ~ec_clr) | edge_pulse;
    end

    // Registered IRQ from either the live level or the captured edges
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else if (IRQ_TYPE == IRQ_LEVEL)
            irq <= |(sync_in & irqmask);
        else
            irq <= |(edgecapture & irqmask);
    end

    // Read mux; unmapped and write-only addresses return 0
    always_comb begin
        rd_next = '0;
        case (address)
            PIO_ADDR_DATA:    rd_next[WIDTH-1:0] = sync_in;
            PIO_ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            PIO_ADDR_OUTREAD: rd_next[WIDTH-1:0] = out_port;
            default:          rd_next = '0;
        endcase
    end

    // Read data register, one-cycle latency, no chipselect qualification
    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_nios_pio_irq.sv
// Self-checking bench for nios_pio_irq: an edge-IRQ instance (WIDTH 32,
// RESET_VALUE 0x5A, rising edges) and a level-IRQ instance (WIDTH 8, any edge).
// Expected read data / irq are queued when a cycle is driven and compared
// after the following clock edge.
module tb_nios_pio_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        cs_e, cs_l;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_e, rd_l;
    logic [31:0] in_e, out_e;
    logic [7:0]  in_l, out_l;
    logic        irq_e, irq_l;

    always #5 clk = ~clk;

    nios_pio_irq #(
        .WIDTH(32), .RESET_VALUE(32'h5A), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)
    ) dut_e (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_e),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e),
        .in_port(in_e), .out_port(out_e), .irq(irq_e)
    );

    nios_pio_irq #(
        .WIDTH(8), .RESET_VALUE(32'h0), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(0)
    ) dut_l (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_l),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l),
        .in_port(in_l), .out_port(out_l), .irq(irq_l)
    );

    typedef struct {
        string       tag;
        int          which;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

`ifdef NIOS_PIO_SETCLR_EN
    localparam bit SETCLR = 1'b1;
`else
    localparam bit SETCLR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle at the falling edge, check results after the rising edge
    task automatic step(input int which, input logic [2:0] a, input bit wr,
                        input logic [31:0] wd, input logic [31:0] xrd,
                        input logic xirq, input string tag);
        exp_t e;
        address   = a;
        writedata = wd;
        write_n   = ~wr;
        cs_e      = wr && (which == 0);
        cs_l      = wr && (which == 1);
        e.tag = tag; e.which = which; e.rd = xrd; e.irq = xirq;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        if (e.which == 0) begin
            chk({e.tag, ".rd"},  rd_e, e.rd);
            chk({e.tag, ".irq"}, {31'b0, irq_e}, {31'b0, e.irq});
        end else begin
            chk({e.tag, ".rd"},  rd_l, e.rd);
            chk({e.tag, ".irq"}, {31'b0, irq_l}, {31'b0, e.irq});
        end
        write_n = 1'b1;
        cs_e    = 1'b0;
        cs_l    = 1'b0;
    endtask

    // Low/high pulse on in_e[0]; optional W1C lands on the same edge as the new capture
    task automatic pulse(input bit w1c, input bit pre);
        for (int s = 1; s <= 6; s++) begin
            logic v;
            v = pre || (s >= 5);
            if (s == 1) in_e[0] = 1'b0;
            if (s == 2) in_e[0] = 1'b1;
            step(0, 3'd2, w1c && (s == 4), 32'h1, {31'b0, v}, v,
                 $sformatf("pulse%0d_%0d", w1c, s));
        end
    endtask

    initial begin
        reset = 1'b1; address = '0; cs_e = 0; cs_l = 0; write_n = 1'b1;
        writedata = '0; in_e = '0; in_l = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out",  out_e, 32'h5A);
        chk("rst_rd",   rd_e, 32'h0);
        chk("rst_irq",  {31'b0, irq_e}, 32'h0);
        chk("rst_outl", {24'b0, out_l}, 32'h0);
        reset = 1'b0;
        step(0, 3'd3, 0, 0, 32'h5A, 0, "oread_rst");

        // DATA write and synchronised input latency
        step(0, 3'd0, 1, 32'hDEADBEEF, 32'h0, 0, "wdata");
        in_e = 32'h12345678;
        for (int n = 1; n <= 3; n++)
            step(0, 3'd0, 0, 0, (n == 3) ? 32'h12345678 : 32'h0, 0, $sformatf("sync%0d", n));
        step(0, 3'd3, 0, 0, 32'hDEADBEEF, 0, "oread");
        in_e = 32'h0;
        step(0, 3'd2, 0, 0, 32'h12345678, 0, "ec_a");
        step(0, 3'd2, 0, 0, 32'h12345678, 0, "ec_b");
        step(0, 3'd2, 1, 32'hFFFFFFFF, 32'h12345678, 0, "ec_clrall");
        step(0, 3'd2, 0, 0, 32'h0, 0, "ec_cleared");

        // Edge capture and edge IRQ on bit 0
        step(0, 3'd1, 1, 32'h1, 32'h0, 0, "mask1");
        in_e = 32'h1;
        for (int n = 1; n <= 4; n++)
            step(0, 3'd2, 0, 0, (n == 4) ? 32'h1 : 32'h0, n == 4, $sformatf("edge%0d", n));
        step(0, 3'd2, 1, 32'h1, 32'h1, 1, "w1c");
        step(0, 3'd2, 0, 0, 32'h0, 0, "w1c_irq");

        // W1C colliding with a fresh edge: edge wins
        pulse(0, 0);
        pulse(1, 1);
        step(0, 3'd2, 1, 32'h1, 32'h1, 1, "clr2");
        step(0, 3'd2, 0, 0, 32'h0, 0, "clr2_irq");

        // Level IRQ instance
        step(1, 3'd1, 1, 32'h4, 32'h0, 0, "lmask");
        in_l = 8'h04;
        for (int n = 1; n <= 3; n++)
            step(1, 3'd0, 0, 0, (n == 3) ? 32'h4 : 32'h0, n == 3, $sformatf("lvl%0d", n));
        step(1, 3'd1, 1, 32'h0, 32'h4, 1, "lmask0");
        step(1, 3'd1, 0, 0, 32'h0, 0, "lmask0_irq");
        step(1, 3'd2, 0, 0, 32'h4, 0, "lec");
        step(1, 3'd0, 1, 32'h1FF, 32'h4, 0, "lwdata");
        step(1, 3'd3, 0, 0, 32'hFF, 0, "loread");
        step(1, 3'd6, 0, 0, 32'h0, 0, "lunmap");
        in_l = 8'h00;

        // Set/clear ports
        step(0, 3'd0, 1, 32'hF0, 32'h1, 0, "out_f0");
        step(0, 3'd4, 1, 32'h0F, 32'h0, 0, "oset");
        step(0, 3'd3, 0, 0, SETCLR ? 32'hFF : 32'hF0, 0, "oset_rd");
        step(0, 3'd5, 1, 32'h81, 32'h0, 0, "oclr");
        step(0, 3'd3, 0, 0, SETCLR ? 32'h7E : 32'hF0, 0, "oclr_rd");
        step(0, 3'd7, 0, 0, 32'h0, 0, "unmap7");

        // Reset overrides a same-cycle write; high input yields an edge after release
        reset = 1'b1; address = 3'd0; writedata = 32'h33; write_n = 1'b0; cs_e = 1'b1;
        @(negedge clk);
        write_n = 1'b1; cs_e = 1'b0;
        chk("mrst_out", out_e, 32'h5A);
        chk("mrst_rd",  rd_e, 32'h0);
        chk("mrst_irq", {31'b0, irq_e}, 32'h0);
        reset = 1'b0;
        for (int n = 1; n <= 4; n++)
            step(0, 3'd2, 0, 0, (n == 4) ? 32'h1 : 32'h0, 0, $sformatf("post_rst%0d", n));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
